// File: rtl/mcpu_core_stage_dtlb_q_pkg.sv
// Shared operation-type and DTLB fault encodings for the core pipeline stages.
package mcpu_core_stage_dtlb_q_pkg;

  localparam logic [1:0] OPER_TYPE_ALU = 2'd0;
  localparam logic [1:0] OPER_TYPE_LSU = 2'd1;
  localparam logic [1:0] OPER_TYPE_BRU = 2'd2;
  localparam logic [1:0] OPER_TYPE_CSR = 2'd3;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_NOTPRES = 2'd1;
  localparam logic [1:0] FAULT_USER    = 2'd2;
  localparam logic [1:0] FAULT_WRPROT  = 2'd3;

  // Highest-priority fault wins: missing page, then privilege, then write protection.
  function automatic logic [1:0] dtlb_fault(input logic present, input logic writable,
                                            input logic user_ok, input logic is_user,
                                            input logic is_write);
    logic [1:0] f;
    f = FAULT_NONE;
    if (!present)                  f = FAULT_NOTPRES;
    else if (is_user && !user_ok)  f = FAULT_USER;
    else if (is_write && !writable) f = FAULT_WRPROT;
    return f;
  endfunction

endpackage

// File: rtl/mcpu_core_sync_fifo.sv
// Synchronous FIFO with occupancy count; registered storage, head visible combinationally.
// Push while full is dropped unless a pop happens the same cycle; flush empties it in one cycle.
module mcpu_core_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clkrst_core_clk,
  input  logic                     clkrst_core_rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != CNT_W'(DEPTH)) | do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/mcpu_core_stage_dtlb_q.sv
// DTLB lookup stage: issues VPN lookups, checks permissions, queues {paddr, fault} results.
// Lookup-to-output 2 cycles; new lookups stall while queued + in-flight results would overflow.
module mcpu_core_stage_dtlb_q
  import mcpu_core_stage_dtlb_q_pkg::*;
#(
  parameter int VA_W      = 32,
  parameter int PAGE_BITS = 12,
  parameter int DEPTH     = 2
) (
  input  logic                   clkrst_core_clk,
  input  logic                   clkrst_core_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VA_W-1:0]        in_vaddr,
  input  logic [1:0]             in_oper_type,
  input  logic                   in_is_write,
  input  logic                   user_mode,
  input  logic                   pipe_flush,
  output logic [VA_W-PAGE_BITS-1:0] dtlb_addr,
  output logic                   dtlb_re,
  output logic                   dtlb_is_write,
  input  logic                   dtlb_ready,
  input  logic [VA_W-PAGE_BITS-1:0] dtlb_phys_addr,
  input  logic [3:0]             dtlb_flags,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [VA_W-1:0]        out_paddr,
  output logic [1:0]             out_fault
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = VA_W + 2;

  logic [PAGE_BITS-1:0] off_q, off_d;
  logic                 wr_q, wr_d;
  logic                 usr_q, usr_d;
  logic                 inflight_q, inflight_d;

  logic [CNT_W-1:0]     count;
  logic [CNT_W:0]       occ;
  logic [ENT_W-1:0]     head_dat, push_dat;
  logic                 is_lsu, can_issue, pop, push;
  logic [1:0]           fault;
  logic                 flags_rsvd_unused;

  assign flags_rsvd_unused = dtlb_flags[3];

  always_comb begin
    out_valid = (count != '0);
    pop       = out_valid & out_ready;
    // Reserve a slot for the in-flight response so a pushed result always fits.
    occ       = (CNT_W+1)'(count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    can_issue = dtlb_ready & (occ < (CNT_W+1)'(DEPTH));
    is_lsu    = (in_oper_type == OPER_TYPE_LSU);
    in_ready  = ~in_valid | ~is_lsu | can_issue;
    dtlb_re   = in_valid & is_lsu & can_issue & ~pipe_flush;

    push     = inflight_q & ~pipe_flush;
    fault    = dtlb_fault(dtlb_flags[0], dtlb_flags[1], dtlb_flags[2], usr_q, wr_q);
    push_dat = {dtlb_phys_addr, off_q, fault};

    off_d      = off_q;
    wr_d       = wr_q;
    usr_d      = usr_q;
    inflight_d = dtlb_re;
    if (dtlb_re) begin
      off_d = in_vaddr[PAGE_BITS-1:0];
      wr_d  = in_is_write;
      usr_d = user_mode;
    end
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      off_q      <= '0;
      wr_q       <= 1'b0;
      usr_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      off_q      <= off_d;
      wr_q       <= wr_d;
      usr_q      <= usr_d;
      inflight_q <= inflight_d;
    end
  end

  mcpu_core_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clkrst_core_clk (clkrst_core_clk),
    .clkrst_core_rst (clkrst_core_rst),
    .push            (push),
    .push_dat        (push_dat),
    .pop             (pop),
    .flush           (pipe_flush),
    .head_dat        (head_dat),
    .count           (count)
  );

  assign dtlb_addr     = in_vaddr[VA_W-1:PAGE_BITS];
  assign dtlb_is_write = in_is_write;
  assign out_paddr     = head_dat[ENT_W-1:2];
  assign out_fault     = head_dat[1:0];

endmodule

// File: tb/tb_mcpu_core_stage_dtlb_q.sv
// Scoreboard bench for the DTLB lookup stage with a one-cycle-latency TLB responder.
module tb_mcpu_core_stage_dtlb_q;
  import mcpu_core_stage_dtlb_q_pkg::*;

  logic        clkrst_core_clk = 1'b0;
  logic        clkrst_core_rst;
  logic        in_valid, in_ready, in_is_write, user_mode, pipe_flush;
  logic [31:0] in_vaddr;
  logic [1:0]  in_oper_type;
  logic [19:0] dtlb_addr;
  logic        dtlb_re, dtlb_is_write, dtlb_ready;
  logic [19:0] dtlb_phys_addr = '0;
  logic [3:0]  dtlb_flags = '0;
  logic        out_valid, out_ready;
  logic [31:0] out_paddr;
  logic [1:0]  out_fault;

  typedef struct packed {
    logic [31:0] paddr;
    logic [1:0]  fault;
  } exp_t;

  exp_t        expq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [19:0] cur_ppn, rsp_ppn;
  logic [3:0]  cur_flags, rsp_flags;
  logic        rsp_pend = 1'b0;

  always #5 clkrst_core_clk = ~clkrst_core_clk;

  mcpu_core_stage_dtlb_q #(.VA_W(32), .PAGE_BITS(12), .DEPTH(2)) dut (
    .clkrst_core_clk (clkrst_core_clk),
    .clkrst_core_rst (clkrst_core_rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_vaddr        (in_vaddr),
    .in_oper_type    (in_oper_type),
    .in_is_write     (in_is_write),
    .user_mode       (user_mode),
    .pipe_flush      (pipe_flush),
    .dtlb_addr       (dtlb_addr),
    .dtlb_re         (dtlb_re),
    .dtlb_is_write   (dtlb_is_write),
    .dtlb_ready      (dtlb_ready),
    .dtlb_phys_addr  (dtlb_phys_addr),
    .dtlb_flags      (dtlb_flags),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_paddr       (out_paddr),
    .out_fault       (out_fault)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_fault(input logic [3:0] fl, input logic usr, input logic wr);
    if (!fl[0])             return 2'd1;
    else if (usr && !fl[2]) return 2'd2;
    else if (wr && !fl[1])  return 2'd3;
    return 2'd0;
  endfunction

  // TLB model: answer each lookup on the following cycle, drive junk otherwise.
  always @(negedge clkrst_core_clk) begin
    rsp_pend  = dtlb_re;
    rsp_ppn   = cur_ppn;
    rsp_flags = cur_flags;
  end

  always @(posedge clkrst_core_clk) begin
    #1;
    if (rsp_pend) begin
      dtlb_phys_addr = rsp_ppn;
      dtlb_flags     = rsp_flags;
    end else begin
      dtlb_phys_addr = 20'h5A5A5;
      dtlb_flags     = 4'b0110;
    end
  end

  always @(negedge clkrst_core_clk) begin : mon
    exp_t e;
    if (!clkrst_core_rst && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = expq.pop_front();
        check("out_fault", 64'(out_fault), 64'(e.fault));
        if (e.fault == 2'd0) check("out_paddr", 64'(out_paddr), 64'(e.paddr));
      end
    end
  end

  task automatic step();
    @(posedge clkrst_core_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] va, input logic wr, input logic usr,
                      input logic [19:0] ppn, input logic [3:0] fl);
    bit ok;
    ok           = 1'b0;
    in_valid     = 1'b1;
    in_oper_type = OPER_TYPE_LSU;
    in_vaddr     = va;
    in_is_write  = wr;
    user_mode    = usr;
    cur_ppn      = ppn;
    cur_flags    = fl;
    for (int i = 0; i < 50; i++) begin
      @(negedge clkrst_core_clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("issue_in_ready", 64'(in_ready), 64'd1);
    check("issue_dtlb_re", 64'(dtlb_re), 64'd1);
    check("dtlb_addr", 64'(dtlb_addr), 64'(va[31:12]));
    check("dtlb_is_write", 64'(dtlb_is_write), 64'(wr));
    if (ok) expq.push_back(exp_t'({ppn, va[11:0], model_fault(fl, usr, wr)}));
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && expq.size() != 0; i++) @(negedge clkrst_core_clk);
    check("drain_empty", 64'(expq.size()), 64'd0);
    step();
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clkrst_core_clk);
      check(tag, 64'(out_valid), 64'd0);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    clkrst_core_rst = 1'b1;
    in_valid = 1'b0; in_oper_type = OPER_TYPE_ALU; in_vaddr = '0;
    in_is_write = 1'b0; user_mode = 1'b0; pipe_flush = 1'b0;
    dtlb_ready = 1'b1; out_ready = 1'b1; cur_ppn = '0; cur_flags = '0;

    repeat (2) @(negedge clkrst_core_clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_dtlb_re", 64'(dtlb_re), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_oper_type = OPER_TYPE_LSU;
    #1;
    check("rst_in_ready_lsu", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    @(negedge clkrst_core_clk);
    clkrst_core_rst = 1'b0;
    step();

    // Basic translation and two-cycle latency.
    send(32'h1234_5678, 1'b0, 1'b0, 20'hABCDE, 4'b0111);
    @(negedge clkrst_core_clk);
    check("lat_cyc1_out_valid", 64'(out_valid), 64'd0);
    @(negedge clkrst_core_clk);
    check("lat_cyc2_out_valid", 64'(out_valid), 64'd1);
    check("lat_paddr", 64'(out_paddr), 64'h0000_0000_ABCD_E678);
    check("lat_fault", 64'(out_fault), 64'd0);
    step();

    // Fault priority cases.
    send(32'h0000_1004, 1'b1, 1'b1, 20'h11111, 4'b0011);
    send(32'h0000_2008, 1'b1, 1'b0, 20'h22222, 4'b0101);
    send(32'h3000_000C, 1'b0, 1'b0, 20'h33333, 4'b0000);
    send(32'h4000_0010, 1'b1, 1'b1, 20'h44444, 4'b0110);
    send(32'h5000_0FFF, 1'b1, 1'b1, 20'h55555, 4'b1111);
    send(32'h6000_0001, 1'b0, 1'b1, 20'h66666, 4'b0101);
    drain();

    // Back-to-back random traffic.
    for (int i = 0; i < 10; i++)
      send($urandom(), 1'($urandom()), 1'($urandom()), 20'($urandom()), 4'($urandom()));
    drain();

    // Queue full: third request stalls until one result drains.
    out_ready = 1'b0;
    send(32'hA000_0111, 1'b0, 1'b0, 20'hA0A0A, 4'b0111);
    send(32'hB000_0222, 1'b0, 1'b0, 20'hB0B0B, 4'b0111);
    in_valid = 1'b1; in_oper_type = OPER_TYPE_LSU; in_vaddr = 32'hC000_0333;
    for (int i = 0; i < 3; i++) begin
      @(negedge clkrst_core_clk);
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("full_dtlb_re", 64'(dtlb_re), 64'd0);
      check("full_out_valid", 64'(out_valid), 64'd1);
      step();
    end
    out_ready = 1'b1;
    send(32'hC000_0333, 1'b0, 1'b0, 20'hC0C0C, 4'b0111);
    drain();

    // Flush with one result queued and one in flight.
    out_ready = 1'b0;
    send(32'hD000_0444, 1'b0, 1'b0, 20'hD0D0D, 4'b0111);
    send(32'hE000_0555, 1'b0, 1'b0, 20'hE0E0E, 4'b0111);
    pipe_flush = 1'b1;
    @(negedge clkrst_core_clk);
    check("flush1_pre_out_valid", 64'(out_valid), 64'd1);
    @(posedge clkrst_core_clk);
    expq.delete();
    #1;
    pipe_flush = 1'b0;
    out_ready  = 1'b1;
    expect_idle("flush1_out_valid", 3);

    // Flush suppresses an otherwise issuable lookup and the pending push.
    out_ready = 1'b0;
    send(32'hF000_0666, 1'b0, 1'b0, 20'hF0F0F, 4'b0111);
    pipe_flush = 1'b1;
    in_valid = 1'b1; in_oper_type = OPER_TYPE_LSU; in_vaddr = 32'h7000_0777;
    @(negedge clkrst_core_clk);
    check("flush2_dtlb_re", 64'(dtlb_re), 64'd0);
    @(posedge clkrst_core_clk);
    expq.delete();
    #1;
    pipe_flush = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    expect_idle("flush2_out_valid", 3);

    // Non-LSU op passes through with the TLB busy; LSU op must wait.
    dtlb_ready = 1'b0;
    in_valid = 1'b1; in_oper_type = OPER_TYPE_ALU; in_vaddr = 32'h8000_0888;
    @(negedge clkrst_core_clk);
    check("nonlsu_in_ready", 64'(in_ready), 64'd1);
    check("nonlsu_dtlb_re", 64'(dtlb_re), 64'd0);
    step();
    in_oper_type = OPER_TYPE_LSU;
    @(negedge clkrst_core_clk);
    check("tlb_busy_in_ready", 64'(in_ready), 64'd0);
    check("tlb_busy_dtlb_re", 64'(dtlb_re), 64'd0);
    step();
    in_valid   = 1'b0;
    dtlb_ready = 1'b1;
    expect_idle("nonlsu_out_valid", 3);

    // Reset pulse while a lookup is in flight.
    send(32'h9000_0999, 1'b0, 1'b0, 20'h90909, 4'b0111);
    clkrst_core_rst = 1'b1;
    expq.delete();
    #2;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    clkrst_core_rst = 1'b0;
    expect_idle("rst_mid_no_entry", 3);

    // Still functional afterwards.
    send(32'h1357_9BDF, 1'b1, 1'b0, 20'h2468A, 4'b0011);
    drain();
    check("end_queue_empty", 64'(expq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
